// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID-stage branch forwarding scoreboard:
// stage indices, forward-select encoding and the scoreboard entry layout.
package pipe_pkg;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Entry rd is stored at this width; REG_AW of any user must not exceed it.
  localparam int MAX_REG_AW = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  is_load;
  } sb_entry_t;

  function automatic int fwd_alu(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int fwd_mem(input int k);
    return 2 * k + 2;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority scan of the scoreboard for one ID source operand: the youngest
// matching entry decides the select, or flags not-ready if its data is late.
module fwd_src_match
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = 3
) (
  input  logic                        i_used,
  input  logic [REG_AW-1:0]           i_rs,
  input  sb_entry_t [DEPTH-1:0]       i_sb,
  output logic [SEL_W-1:0]            o_sel,
  output logic                        o_not_ready
);

  logic [MAX_REG_AW-1:0] w_rs;
  logic                  w_found;

  assign w_rs = MAX_REG_AW'(i_rs);

  always_comb begin
    o_sel       = SEL_W'(FWD_RF);
    o_not_ready = 1'b0;
    w_found     = 1'b0;
    if (i_used && (i_rs != '0)) begin
      // Older matches are shadowed even when the youngest one is not ready.
      for (int k = STG_EX; k < DEPTH; k++) begin
        if (!w_found && i_sb[k].valid && (i_sb[k].rd == w_rs)) begin
          w_found = 1'b1;
          if (i_sb[k].is_load) begin
            if (k >= LOAD_READY) o_sel = SEL_W'(fwd_mem(k));
            else                 o_not_ready = 1'b1;
          end else begin
            if (k >= ALU_READY)  o_sel = SEL_W'(fwd_alu(k));
            else                 o_not_ready = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// ID-stage branch operand forwarding: shift-register scoreboard of in-flight
// destinations, per-source forward selects, load-use/ALU stall and stall counter.
module branch_fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(2 * DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic                       id_rd_we,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [DEPTH-1:0]           stg_valid,
  output logic [31:0]                stall_cycles
);

  sb_entry_t [DEPTH-1:0] r_sb;
  sb_entry_t             w_new;
  logic [NUM_SRC-1:0]    w_not_ready;
  logic [31:0]           r_stall_cycles;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .DEPTH      (DEPTH),
      .REG_AW     (REG_AW),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_match (
      .i_used      (id_rs_used[s]),
      .i_rs        (id_rs[s*REG_AW +: REG_AW]),
      .i_sb        (r_sb),
      .o_sel       (fwd_sel[s*SEL_W +: SEL_W]),
      .o_not_ready (w_not_ready[s])
    );
  end

  // Flush overrides stall; either one turns the EX insertion into a bubble.
  assign stall = id_valid & ~flush & (|w_not_ready);

  always_comb begin
    w_new.valid   = id_valid & id_rd_we & (id_rd != '0) & ~stall & ~flush;
    w_new.rd      = MAX_REG_AW'(id_rd);
    w_new.is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb           <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_sb[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
      if (stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_vld
    assign stg_valid[k] = r_sb[k].valid;
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a
// negedge monitor pops and compares against one of three DUT configurations.
module tb_branch_fwd_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [14:0] id_rs;
  logic [2:0]  id_rs_used;
  logic        id_rd_we;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        flush;

  logic [5:0]  a_sel, b_sel;
  logic [8:0]  c_sel;
  logic        a_stall, b_stall, c_stall;
  logic [2:0]  a_stgv, b_stgv, c_stgv;
  logic [31:0] a_cnt, b_cnt, c_cnt;

  branch_fwd_scoreboard u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs[9:0]),
    .id_rs_used(id_rs_used[1:0]), .id_rd_we(id_rd_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(a_sel), .stall(a_stall),
    .stg_valid(a_stgv), .stall_cycles(a_cnt)
  );

  branch_fwd_scoreboard #(.LOAD_READY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs[9:0]),
    .id_rs_used(id_rs_used[1:0]), .id_rd_we(id_rd_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(b_sel), .stall(b_stall),
    .stg_valid(b_stgv), .stall_cycles(b_cnt)
  );

  branch_fwd_scoreboard #(.NUM_SRC(3)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd_we(id_rd_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(c_sel), .stall(c_stall),
    .stg_valid(c_stgv), .stall_cycles(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    string       name;
    logic [8:0]  sel;
    logic        stall;
    logic [2:0]  stgv;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [8:0]  g_sel;
    logic        g_stall;
    logic [2:0]  g_stgv;
    logic [31:0] g_cnt;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.dut)
        0:       begin g_sel = {3'b000, a_sel}; g_stall = a_stall; g_stgv = a_stgv; g_cnt = a_cnt; end
        1:       begin g_sel = {3'b000, b_sel}; g_stall = b_stall; g_stgv = b_stgv; g_cnt = b_cnt; end
        default: begin g_sel = c_sel;           g_stall = c_stall; g_stgv = c_stgv; g_cnt = c_cnt; end
      endcase
      chk(e.name, "fwd_sel",      32'(g_sel),   32'(e.sel));
      chk(e.name, "stall",        32'(g_stall), 32'(e.stall));
      chk(e.name, "stg_valid",    32'(g_stgv),  32'(e.stgv));
      chk(e.name, "stall_cycles", g_cnt,        e.cnt);
    end
  end

  task automatic push(input int d, input string nm, input logic [8:0] sel,
                      input logic st, input logic [2:0] stgv, input logic [31:0] cnt);
    exp_t e;
    e.dut = d; e.name = nm; e.sel = sel; e.stall = st; e.stgv = stgv; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic exp_a(input string nm, input logic [2:0] s0, input logic [2:0] s1,
                       input logic st, input logic [2:0] stgv, input logic [31:0] cnt);
    push(0, nm, {3'b000, s1, s0}, st, stgv, cnt);
  endtask

  task automatic exp_b(input string nm, input logic [2:0] s0, input logic [2:0] s1,
                       input logic st, input logic [2:0] stgv, input logic [31:0] cnt);
    push(1, nm, {3'b000, s1, s0}, st, stgv, cnt);
  endtask

  task automatic exp_c(input string nm, input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                       input logic st, input logic [2:0] stgv, input logic [31:0] cnt);
    push(2, nm, {s2, s1, s0}, st, stgv, cnt);
  endtask

  task automatic drv(input logic v, input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] used, input logic we, input logic [4:0] rd,
                     input logic ld, input logic fl);
    id_valid   = v;
    id_rs      = {rs2, rs1, rs0};
    id_rs_used = used;
    id_rd_we   = we;
    id_rd      = rd;
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with a live ID instruction: nothing may be tracked.
    rst_n = 1'b0;
    drv(1, 5, 0, 0, 3'b001, 1, 5, 0, 0);
    exp_a("reset", 0, 0, 0, 3'b000, 0);
    exp_c("reset_c", 0, 0, 0, 0, 3'b000, 0);
    tick();
    exp_a("reset_held", 0, 0, 0, 3'b000, 0);
    tick();
    rst_n = 1'b1;
    idle(); exp_a("post_rst", 0, 0, 0, 3'b000, 0); tick();
    idle(); exp_a("post_rst2", 0, 0, 0, 3'b000, 0); tick();

    // ALU result in MEM
    drv(1, 0, 0, 0, 3'b000, 1, 5, 0, 0); exp_a("mem_issue", 0, 0, 0, 3'b000, 0); tick();
    idle();                               exp_a("mem_bubble", 0, 0, 0, 3'b001, 0); tick();
    drv(1, 5, 6, 0, 3'b011, 0, 0, 0, 0); exp_a("alu_mem_fwd", 3, 0, 0, 3'b010, 0); tick();
    idle();                               exp_a("mem_wb", 0, 0, 0, 3'b100, 0); tick();
    idle();                               exp_a("mem_drain", 0, 0, 0, 3'b000, 0); tick();

    // ALU result in EX: stall 1 cycle, stalled writer must not be inserted
    drv(1, 0, 0, 0, 3'b000, 1, 5, 0, 0); exp_a("ex_issue", 0, 0, 0, 3'b000, 0); tick();
    drv(1, 5, 6, 0, 3'b011, 1, 9, 0, 0); exp_a("alu_ex_stall", 0, 0, 1, 3'b001, 0); tick();
    drv(1, 5, 6, 0, 3'b011, 1, 9, 0, 0); exp_a("alu_ex_fwd", 3, 0, 0, 3'b010, 1); tick();
    idle(); exp_a("alu_ex_ins", 0, 0, 0, 3'b101, 1); tick();
    idle(); exp_a("ex_drain1", 0, 0, 0, 3'b010, 1); tick();
    idle(); exp_a("ex_drain2", 0, 0, 0, 3'b100, 1); tick();
    idle(); exp_a("ex_drain3", 0, 0, 0, 3'b000, 1); tick();

    // Load-use on source 1
    drv(1, 0, 0, 0, 3'b000, 1, 7, 1, 0); exp_a("lw_issue", 0, 0, 0, 3'b000, 1); tick();
    drv(1, 6, 7, 0, 3'b011, 0, 0, 0, 0); exp_a("load_use_stall", 0, 0, 1, 3'b001, 1); tick();
    drv(1, 6, 7, 0, 3'b011, 0, 0, 0, 0); exp_a("load_use_fwd", 0, 4, 0, 3'b010, 2); tick();
    idle(); exp_a("lu_drain1", 0, 0, 0, 3'b100, 2); tick();
    idle(); exp_a("lu_drain2", 0, 0, 0, 3'b000, 2); tick();

    // Youngest match wins even when not ready
    drv(1, 0, 0, 0, 3'b000, 1, 5, 0, 0); exp_a("prio_addi", 0, 0, 0, 3'b000, 2); tick();
    drv(1, 0, 0, 0, 3'b000, 1, 5, 1, 0); exp_a("prio_lw", 0, 0, 0, 3'b001, 2); tick();
    drv(1, 5, 0, 0, 3'b001, 0, 0, 0, 0); exp_a("prio_stall", 0, 0, 1, 3'b011, 2); tick();
    drv(1, 5, 0, 0, 3'b001, 0, 0, 0, 0); exp_a("prio_mem", 4, 0, 0, 3'b110, 3); tick();
    idle(); exp_a("prio_drain1", 0, 0, 0, 3'b100, 3); tick();
    idle(); exp_a("prio_drain2", 0, 0, 0, 3'b000, 3); tick();

    // x0 never tracked; unused sources never match
    drv(1, 0, 0, 0, 3'b000, 1, 0, 0, 0); exp_a("x0_write", 0, 0, 0, 3'b000, 3); tick();
    drv(1, 0, 0, 0, 3'b011, 1, 5, 0, 0); exp_a("x0_read", 0, 0, 0, 3'b000, 3); tick();
    drv(1, 5, 5, 0, 3'b000, 0, 0, 0, 0); exp_a("unused_src", 0, 0, 0, 3'b001, 3); tick();
    idle(); exp_a("x0_drain1", 0, 0, 0, 3'b010, 3); tick();
    idle(); exp_a("x0_drain2", 0, 0, 0, 3'b100, 3); tick();
    idle(); exp_a("x0_drain3", 0, 0, 0, 3'b000, 3); tick();

    // Flush beats stall: no stall, no insertion, counter unchanged
    drv(1, 0, 0, 0, 3'b000, 1, 7, 1, 0); exp_a("fl_lw", 0, 0, 0, 3'b000, 3); tick();
    drv(1, 6, 7, 0, 3'b011, 1, 9, 0, 1); exp_a("flush_stall", 0, 0, 0, 3'b001, 3); tick();
    idle(); exp_a("flush_bubble", 0, 0, 0, 3'b010, 3); tick();
    idle(); exp_a("fl_drain1", 0, 0, 0, 3'b100, 3); tick();
    idle(); exp_a("fl_drain2", 0, 0, 0, 3'b000, 3); tick();

    // LOAD_READY=2: two stall cycles, then WB memory data
    rst_n = 1'b0; idle(); exp_b("b_reset", 0, 0, 0, 3'b000, 0); tick(); rst_n = 1'b1;
    drv(1, 0, 0, 0, 3'b000, 1, 7, 1, 0); exp_b("lr2_lw", 0, 0, 0, 3'b000, 0); tick();
    drv(1, 6, 7, 0, 3'b011, 0, 0, 0, 0); exp_b("lr2_stall1", 0, 0, 1, 3'b001, 0); tick();
    drv(1, 6, 7, 0, 3'b011, 0, 0, 0, 0); exp_b("lr2_stall2", 0, 0, 1, 3'b010, 1); tick();
    drv(1, 6, 7, 0, 3'b011, 0, 0, 0, 0); exp_b("lr2_fwd", 0, 6, 0, 3'b100, 2); tick();
    idle(); exp_b("lr2_drain", 0, 0, 0, 3'b000, 2); tick();

    // NUM_SRC=3: three sources hitting three stages at once
    pulse_reset();
    drv(1, 0, 0, 0, 3'b000, 1, 3, 0, 0); exp_c("c_x3", 0, 0, 0, 0, 3'b000, 0); tick();
    drv(1, 0, 0, 0, 3'b000, 1, 2, 0, 0); exp_c("c_x2", 0, 0, 0, 0, 3'b001, 0); tick();
    drv(1, 0, 0, 0, 3'b000, 1, 1, 0, 0); exp_c("c_x1", 0, 0, 0, 0, 3'b011, 0); tick();
    drv(1, 2, 3, 1, 3'b111, 0, 0, 0, 0); exp_c("three_src", 3, 5, 0, 1, 3'b111, 0); tick();
    drv(1, 2, 3, 1, 3'b111, 0, 0, 0, 0); exp_c("three_src_adv", 5, 0, 3, 0, 3'b110, 1); tick();
    idle(); tick();

    @(negedge clk);
    #1;
    chk("drain", "queue_left", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
